// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: RV32 load/store size codes and data-memory FSM states
package riscv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: byte-lane strobes, store alignment, load extension and access legality
module dmem_lane_fmt
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  byte_strb,
  output logic [31:0] wdata_shifted,
  output logic [31:0] load_ext,
  output logic        fault
);
  logic [15:0] sh;
  logic        illegal, misal;
  always_comb begin
    illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && funct3[2]);
    misal = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3 == F3_W && addr_lo != 2'b00);
    fault = illegal || misal;
    byte_strb = fault ? 4'h0 : funct3 == F3_W ? 4'hF :
                funct3 == F3_H ? 4'b0011 << addr_lo : 4'b0001 << addr_lo;
    wdata_shifted = wdata << {addr_lo, 3'b000};
    sh = 16'(raw >> {addr_lo, 3'b000});
    load_ext = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == F3_BU ? {24'h0, sh[7:0]} :
               funct3 == F3_H  ? {{16{sh[15]}}, sh} :
               funct3 == F3_HU ? {16'h0, sh} :
               funct3 == F3_W  ? raw : '0;
  end
endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed RV32 data memory with lane strobes, fault flagging and a post-reset clear sweep
module dmem_bytelane
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int RD_LAT = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault,
  output logic        busy
);
  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [AW-1:0] clr_cnt, idx, widx;
  logic [3:0]    strb, wstrb;
  logic [31:0]   wsh, wd, ld_ext, ld_data;
  logic          flt, ld, unused_addr;
  assign idx = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign busy = state == CLEAR;
  dmem_lane_fmt u_fmt (
    .funct3,
    .addr_lo(addr[1:0]),
    .we(req_we),
    .wdata,
    .raw(mem[idx]),
    .byte_strb(strb),
    .wdata_shifted(wsh),
    .load_ext(ld_ext),
    .fault(flt)
  );
  assign fault = req_valid && !busy && flt;
  assign ld = req_valid && !req_we && !busy && !flt;
  assign ld_data = ld ? ld_ext : '0;
  // the clear sweep borrows the single write port while busy
  assign wstrb = busy ? 4'hF : (req_valid && req_we) ? strb : 4'h0;
  assign widx = busy ? clr_cnt : idx;
  assign wd = busy ? '0 : wsh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) state <= RUN;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
  generate
    if (RD_LAT == 1) begin : g_reg
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          rdata <= '0;
          rvalid <= 1'b0;
        end else begin
          rdata <= ld_data;
          rvalid <= ld;
        end
    end else begin : g_comb
      assign rdata = ld_data;
      assign rvalid = ld;
    end
  endgenerate
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: checks both read latencies side by side against a byte-array reference model
module tb_dmem_bytelane;
  logic        clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, fault0, fault1, busy0, busy1;
  logic [7:0]  m [256];
  logic [31:0] r;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  dmem_bytelane #(.DEPTH(64), .RD_LAT(0)) d0 (
    .clk, .rst, .req_valid, .req_we, .funct3, .addr, .wdata,
    .rdata(rdata0), .rvalid(rvalid0), .fault(fault0), .busy(busy0)
  );
  dmem_bytelane #(.DEPTH(64), .RD_LAT(1)) d1 (
    .clk, .rst, .req_valid, .req_we, .funct3, .addr, .wdata,
    .rdata(rdata1), .rvalid(rvalid1), .fault(fault1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd);
    int n;
    logic legal, ef, erv;
    logic [31:0] er;
    @(negedge clk);
    req_valid = 1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ef = !legal || (a % n != 0);
    erv = !we && !ef;
    er = 0;
    if (erv) begin
      for (int i = 0; i < n; i++) er |= 32'(m[8'(a + i)]) << (8 * i);
      if (!f3[2] && n < 4 && er[8*n-1]) er |= 32'hFFFF_FFFF << (8 * n);
    end
    #1;
    chk("fault_l0", 32'(fault0), 32'(ef));
    chk("fault_l1", 32'(fault1), 32'(ef));
    chk("rvalid_l0", 32'(rvalid0), 32'(erv));
    chk("rdata_l0", rdata0, er);
    rd = rdata0;
    @(posedge clk); #1;
    chk("rvalid_l1", 32'(rvalid1), 32'(erv));
    chk("rdata_l1", rdata1, er);
    if (we && !ef) for (int i = 0; i < n; i++) m[8'(a + i)] = wd[8*i +: 8];
    req_valid = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 0;
    #1;
    chk("idle_fault", 32'(fault0), 0);
    chk("idle_rdata_l0", rdata0, 0);
    @(posedge clk); #1;
    chk("idle_rvalid_l1", 32'(rvalid1), 0);
    chk("idle_rdata_l1", rdata1, 0);
  endtask

  task automatic reset_sweep(input int abort);
    int n;
    @(negedge clk);
    rst = 1; req_valid = 0;
    #2;
    chk("rst_busy", 32'(busy0), 1);
    chk("rst_rvalid_l1", 32'(rvalid1), 0);
    chk("rst_rdata_l1", rdata1, 0);
    @(negedge clk);
    rst = 0;
    if (abort > 0) begin
      repeat (abort) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
    end
    foreach (m[i]) m[i] = 0;
    n = 0;
    while (busy0 && n < 200) begin
      req_valid = 1; req_we = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; wdata = $urandom;
      #1;
      chk("busy_fault", 32'(fault0 | fault1), 0);
      chk("busy_rvalid", 32'(rvalid0 | rvalid1), 0);
      chk("busy_rdata_l0", rdata0, 0);
      chk("busy_l1", 32'(busy1), 1);
      n++;
      @(negedge clk);
    end
    req_valid = 0;
    chk("busy_len", 32'(n), 64);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_sweep(0);
    for (int i = 0; i < 4; i++) begin
      acc(0, 3'b010, $urandom & 32'hFFFF_FFFC, 0, r);
      chk("t1_zero", r, 0);
    end
    acc(1, 3'b010, 32'h40, 32'h8000_12F0, r);
    acc(0, 3'b000, 32'h40, 0, r); chk("t2_lb", r, 32'hFFFF_FFF0);
    acc(0, 3'b100, 32'h40, 0, r); chk("t2_lbu", r, 32'h0000_00F0);
    acc(0, 3'b001, 32'h42, 0, r); chk("t2_lh", r, 32'hFFFF_8000);
    acc(0, 3'b101, 32'h42, 0, r); chk("t2_lhu", r, 32'h0000_8000);
    acc(0, 3'b010, 32'h40, 0, r); chk("t2_lw", r, 32'h8000_12F0);
    acc(1, 3'b010, 32'h10, 0, r);
    acc(1, 3'b000, 32'h13, 32'hFFFF_FFAB, r);
    acc(1, 3'b001, 32'h10, 32'hDEAD_1234, r);
    acc(0, 3'b010, 32'h10, 0, r); chk("t3_lanes", r, 32'hAB00_1234);
    acc(1, 3'b010, 32'h20, 32'hCAFE_F00D, r);
    acc(0, 3'b010, 32'h41, 0, r);
    acc(1, 3'b001, 32'h23, 32'hBEEF, r);
    acc(1, 3'b011, 32'h20, 32'h1, r);
    acc(1, 3'b100, 32'h20, 32'h77, r);
    acc(0, 3'b011, 32'h20, 0, r);
    acc(0, 3'b010, 32'h20, 0, r); chk("t4_unchanged", r, 32'hCAFE_F00D);
    acc(0, 3'b010, 32'h40, 0, r); chk("t4_unchanged40", r, 32'h8000_12F0);
    acc(1, 3'b010, 32'h100, 32'h5A5A_5A5A, r);
    acc(0, 3'b010, 32'h0, 0, r); chk("t5_wrap", r, 32'h5A5A_5A5A);
    acc(0, 3'b010, 32'h40, 0, r); chk("t5_old", r, 32'h8000_12F0);
    acc(1, 3'b010, 32'h40, 32'h1111_1111, r);
    acc(0, 3'b010, 32'h40, 0, r); chk("t5_new", r, 32'h1111_1111);
    idle();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) idle();
      else acc(1'($urandom), 3'($urandom), $urandom_range(0, 1023), $urandom, r);
    end
    reset_sweep(20);
    for (int i = 0; i < 8; i++) acc(1, 3'b010, 32'(i * 12), $urandom | 1, r);
    reset_sweep(0);
    for (int i = 0; i < 8; i++) begin
      acc(0, 3'b010, 32'(i * 12), 0, r);
      chk("t6_cleared", r, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
